// File: rtl/div_result_buffer_if.sv
// Handshake and data bundle between the array divider, the result buffer and downstream.
// The buffer takes the slave side; whoever drives issue/divider/ready takes the master side.
interface div_result_buffer_if #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned DEPTH     = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                 issue_valid;
  logic                 issue_ok;
  logic                 div_valid;
  logic [DATAWIDTH-1:0] div_q;
  logic [DATAWIDTH-1:0] div_r;
  logic                 m_valid;
  logic                 m_ready;
  logic [DATAWIDTH-1:0] m_q;
  logic [DATAWIDTH-1:0] m_r;
  logic [CW-1:0]        count;
  logic                 overflow;
  logic                 spurious;

  modport master (
    output issue_valid, div_valid, div_q, div_r, m_ready,
    input  issue_ok, m_valid, m_q, m_r, count, overflow, spurious
  );

  modport slave (
    input  issue_valid, div_valid, div_q, div_r, m_ready,
    output issue_ok, m_valid, m_q, m_r, count, overflow, spurious
  );
endinterface

// File: rtl/div_result_buffer.sv
// Credit-tracked result FIFO behind a fixed-latency array divider: counts operations in
// flight so upstream never issues more results than the FIFO can absorb.
module div_result_buffer #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned DEPTH     = 4
) (
  input  logic               clk,
  input  logic               rst,
  div_result_buffer_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW = CW + 1;

  typedef struct packed {
    logic [DATAWIDTH-1:0] q;
    logic [DATAWIDTH-1:0] r;
  } result_t;

  result_t       mem_q [DEPTH];
  result_t       mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic          overflow_q, overflow_d;
  logic          spurious_q, spurious_d;

  logic          pop;
  logic          full;
  logic          push;
  logic          retire;
  logic [SW-1:0] credit_sum;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Push/pop decisions and next-state for pointers, occupancy, credits and sticky flags
  always_comb begin
    pop    = (count_q != '0) && bus.m_ready;
    full   = (count_q == CW'(DEPTH));
    push   = bus.div_valid && (!full || pop);
    retire = push && (inflight_q != '0);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    overflow_d = overflow_q;
    spurious_d = spurious_q;

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);

    // Issue counts even without credit, but never past DEPTH
    if (bus.issue_valid && !retire) begin
      if (inflight_q != CW'(DEPTH)) inflight_d = inflight_q + CW'(1);
    end else if (!bus.issue_valid && retire) begin
      inflight_d = inflight_q - CW'(1);
    end

    if (bus.div_valid && !push)              overflow_d = 1'b1;
    if (bus.div_valid && inflight_q == '0)   spurious_d = 1'b1;
  end

  // Storage write port
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = '{q: bus.div_q, r: bus.div_r};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      overflow_q <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      overflow_q <= overflow_d;
      spurious_q <= spurious_d;
    end
  end

  // All outputs derive from registers only; no path from div_* to m_*
  assign credit_sum   = {1'b0, inflight_q} + {1'b0, count_q};
  assign bus.issue_ok = (credit_sum < SW'(DEPTH));
  assign bus.m_valid  = (count_q != '0);
  assign bus.m_q      = mem_q[rd_ptr_q].q;
  assign bus.m_r      = mem_q[rd_ptr_q].r;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.spurious = spurious_q;
endmodule

// File: doc/div_result_buffer.md
DIV_RESULT_BUFFER -- requirements
Module: div_result_buffer

Interface
REQ-001 Parameter DATAWIDTH, default 8, width of quotient and remainder words; SHALL match the upstream array divider's DATAWIDTH.
REQ-002 Parameter DEPTH, default 4, number of result FIFO entries; SHALL be at least 2.
REQ-003 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, asynchronous active-low reset.
REQ-005 Port issue_valid, input, 1, asserted in any cycle a dividend/divisor pair enters the divider (same net as divider i_valid).
REQ-006 Port issue_ok, output, 1, credit available; upstream SHALL assert issue_valid only while issue_ok=1.
REQ-007 Port div_valid, input, 1, divider o_valid.
REQ-008 Port div_q, input, DATAWIDTH, divider Q_out.
REQ-009 Port div_r, input, DATAWIDTH, divider R_out.
REQ-010 Port m_valid, output, 1, result available downstream.
REQ-011 Port m_ready, input, 1, downstream accepts result.
REQ-012 Port m_q, output, DATAWIDTH, head quotient.
REQ-013 Port m_r, output, DATAWIDTH, head remainder.
REQ-014 Port count, output, $clog2(DEPTH+1), FIFO occupancy.
REQ-015 Port overflow, output, 1, sticky: a result was dropped.
REQ-016 Port spurious, output, 1, sticky: div_valid seen with no operation in flight.

Function
REQ-017 inflight counter (0..DEPTH) SHALL increment on issue_valid, decrement on accepted div_valid, hold on both/neither.
REQ-018 issue_ok SHALL be combinational from registers only: issue_ok = (inflight + count < DEPTH).
REQ-019 Result FIFO SHALL be circular: write pointer, read pointer, count; pointers wrap DEPTH-1 -> 0.
REQ-020 Push on div_valid when count<DEPTH, or when count==DEPTH and pop occurs in the same cycle.
REQ-021 Pop when m_valid && m_ready.
REQ-022 m_valid SHALL equal (count != 0); m_q/m_r SHALL show the entry at the read pointer, registered storage, no combinational path from div_* to m_*.
REQ-023 Latency: div_valid in cycle t -> visible on m_valid/m_q/m_r in cycle t+1 when FIFO was empty.
REQ-024 Simultaneous push and pop: count unchanged, both pointers advance; on empty FIFO push+pop is impossible (m_valid=0), so the word is stored.
REQ-025 m_q/m_r SHALL hold stable while m_valid=1 and m_ready=0.
REQ-026 div_valid with count==DEPTH and no pop: word dropped, state unchanged except overflow set to 1.
REQ-027 div_valid with inflight==0: word still pushed per REQ-020, inflight stays 0, spurious set to 1.
REQ-028 issue_valid while issue_ok=0: inflight still increments (saturating at DEPTH); no other action.
REQ-029 Results SHALL leave in strict arrival order; no reordering, no duplication.

Reset
REQ-030 rst=0 SHALL asynchronously clear inflight, count, pointers, overflow, spurious; outputs: m_valid=0, count=0, issue_ok=1, overflow=0, spurious=0; m_q/m_r=0.
REQ-031 Reset mid-operation SHALL discard all stored and in-flight results; div_valid arriving after release with inflight==0 SHALL set spurious.
REQ-032 Release of rst SHALL be sampled synchronously; first state update on the first clk edge with rst=1.

Verification (DATAWIDTH=8, DEPTH=4, divider LATENCY=3)
REQ-033 Issue 100/7 once, m_ready=1 -> m_valid one cycle after div_valid, m_q=14, m_r=2, count returns to 0, issue_ok=1 throughout.
REQ-034 Issue 4 ops back-to-back, m_ready=0 -> issue_ok=0 from cycle after 4th issue; count reaches 4; raising m_ready drains in issue order, issue_ok=1 after first pop.
REQ-035 FIFO full, m_ready=1 and div_valid same cycle -> count stays 4, no word lost, overflow=0.
REQ-036 Force div_valid with count=4, m_ready=0 -> overflow=1 and stays 1 until rst; FIFO contents unchanged.
REQ-037 Pulse div_valid after reset with no issue -> spurious=1, count=1, inflight=0.
REQ-038 Assert rst with count=3, inflight=2 -> immediately m_valid=0, count=0, issue_ok=1; random 1000-op stream with random m_ready versus reference model -> no mismatch, overflow=0.
